// File: rtl/step_1.sv
// Registered two-level carry-lookahead adder: sum = a + b + cin, carry = sum[WIDTH].
// Define STEP_1_IN_REG_EN to register a/b/cin ahead of the CLA (latency 2 instead of 1).
module step_1 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH:0]   sum,
    output logic             carry
);

    localparam int NBLK = WIDTH / 4;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;

`ifdef STEP_1_IN_REG_EN
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             cin_q, cin_d;

    always_comb begin
        a_d   = a;
        b_d   = b;
        cin_d = cin;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            cin_q <= cin_d;
        end
    end

    assign op_a   = a_q;
    assign op_b   = b_q;
    assign op_cin = cin_q;
`else
    assign op_a   = a;
    assign op_b   = b;
    assign op_cin = cin;
`endif

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] c;
    logic [NBLK-1:0]  blk_g;
    logic [NBLK-1:0]  blk_p;
    logic [NBLK:0]    blk_c;
    logic             term_or;
    logic             prod;
    logic [WIDTH:0]   sum_d, sum_q;
    logic             carry_d, carry_q;

    always_comb begin
        g       = op_a & op_b;
        p       = op_a ^ op_b;
        blk_g   = '0;
        blk_p   = '0;
        blk_c   = '0;
        c       = '0;
        term_or = 1'b0;
        prod    = 1'b0;

        for (int k = 0; k < NBLK; k++) begin
            blk_g[k] = g[k*4+3]
                     | (p[k*4+3] & g[k*4+2])
                     | (p[k*4+3] & p[k*4+2] & g[k*4+1])
                     | (p[k*4+3] & p[k*4+2] & p[k*4+1] & g[k*4]);
            blk_p[k] = &p[k*4 +: 4];
        end

        // Second level: each block carry-in is a flat sum of products over cin and all lower G/P.
        blk_c[0] = op_cin;
        for (int k = 1; k <= NBLK; k++) begin
            term_or = 1'b0;
            for (int j = 0; j < k; j++) begin
                prod = blk_g[j];
                for (int m = j + 1; m < k; m++) begin
                    prod = prod & blk_p[m];
                end
                term_or = term_or | prod;
            end
            prod = op_cin;
            for (int m = 0; m < k; m++) begin
                prod = prod & blk_p[m];
            end
            blk_c[k] = term_or | prod;
        end

        for (int k = 0; k < NBLK; k++) begin
            c[k*4]   = blk_c[k];
            c[k*4+1] = g[k*4] | (p[k*4] & blk_c[k]);
            c[k*4+2] = g[k*4+1]
                     | (p[k*4+1] & g[k*4])
                     | (p[k*4+1] & p[k*4] & blk_c[k]);
            c[k*4+3] = g[k*4+2]
                     | (p[k*4+2] & g[k*4+1])
                     | (p[k*4+2] & p[k*4+1] & g[k*4])
                     | (p[k*4+2] & p[k*4+1] & p[k*4] & blk_c[k]);
        end

        sum_d   = {blk_c[NBLK], p ^ c};
        carry_d = blk_c[NBLK];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign sum   = sum_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_step_1.sv
// Bench for step_1: directed corner cases plus random vectors against an arithmetic reference
// model; expected results travel through a queue sized to the configured latency.
module tb_step_1;

    localparam int WIDTH = 8;
`ifdef STEP_1_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] a     = 8'h00;
    logic [7:0] b     = 8'h00;
    logic       cin   = 1'b0;
    logic [8:0] sum;
    logic       carry;

    int tests = 0;
    int fails = 0;
    logic [8:0] expQ[$];

    step_1 #(.WIDTH(WIDTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (sum),
        .carry(carry)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [8:0] expSum);
        logic expCarry;
        expCarry = expSum[8];
        tests++;
        assert (sum === expSum) else begin
            fails++;
            $error("[TB] FAIL %s sum: observed %h expected %h", tag, sum, expSum);
        end
        tests++;
        assert (carry === expCarry) else begin
            fails++;
            $error("[TB] FAIL %s carry: observed %b expected %b", tag, carry, expCarry);
        end
    endtask

    // Called at a falling edge; drives operands, checks the result due after the next rising edge,
    // and returns at the following falling edge.
    task automatic applyStimulus(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                                 input logic tc);
        logic [8:0] expSum;
        a   = ta;
        b   = tb;
        cin = tc;
        expQ.push_back({1'b0, ta} + {1'b0, tb} + {8'd0, tc});
        @(posedge clk);
        #1;
        expSum = expQ.pop_front();
        checkOutput(tag, expSum);
        @(negedge clk);
    endtask

    task automatic resetQueue();
        expQ.delete();
        for (int i = 0; i < LAT - 1; i++) expQ.push_back(9'd0);
    endtask

    initial begin
        $display("[TB] start, latency %0d", LAT);

        // Load nonzero results so the asynchronous clear is observable.
        a   = 8'hAA;
        b   = 8'h55;
        cin = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_async", 9'h000);
        @(posedge clk);
        #1;
        checkOutput("reset_hold", 9'h000);
        @(negedge clk);
        rst_n = 1'b1;
        resetQueue();

        applyStimulus("max",         8'hFF, 8'hFF, 1'b1);
        applyStimulus("group_carry", 8'h0F, 8'h01, 1'b0);
        applyStimulus("full_ripple", 8'hFF, 8'h00, 1'b1);
        applyStimulus("zero",        8'h00, 8'h00, 1'b0);
        applyStimulus("b2b_first",   8'd100, 8'd27, 1'b0);
        applyStimulus("b2b_second",  8'd200, 8'd100, 1'b1);

        for (int i = 0; i < 1200; i++) begin
            applyStimulus("random", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                          1'($urandom_range(0, 1)));
        end

        // Mid-stream reset: outputs clear at once, in-flight results are dropped.
        applyStimulus("pre_reset_a", 8'h80, 8'h80, 1'b0);
        applyStimulus("pre_reset_b", 8'h12, 8'h34, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_async", 9'h000);
        @(posedge clk);
        #1;
        checkOutput("midreset_hold", 9'h000);
        @(negedge clk);
        rst_n = 1'b1;
        resetQueue();

        applyStimulus("post_reset", 8'd77, 8'd200, 1'b1);
        for (int i = 0; i < 20; i++) begin
            applyStimulus("post_random", 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                          1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < LAT - 1; i++) begin
            applyStimulus("drain", 8'h01, 8'h02, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
